// File: rtl/mat_result_drain.sv
// Purpose : captures a finished N*N result tile from the multiplier and streams its elements out one per beat.
// Latency : a capture at edge k presents element [0][0] with m_valid=1 after edge k; a matrix needs N*N accepted beats.
// Backpr. : m_ready=0 holds the current element stable; captures are refused (and counted as drops) while streaming.
//
// Ports:
//   clk, resetn           clock (rising edge) and asynchronous active-low reset
//   valid_in, last_in     result strobe and end-of-accumulation qualifier from the multiplier
//   result_in             packed signed matrix [row][col][W_OUT]; element [0][0] in the low bits
//   cap_ready             a capture presented this cycle will be taken
//   m_valid/m_ready       output stream handshake
//   m_data/m_row/m_col    current element and its coordinates
//   m_last                final element of the matrix
//   clr_err               synchronous clear of overflow and drop_cnt
//   overflow, drop_cnt    sticky drop flag and saturating drop count
//
// Build option: define MAT_DRAIN_COL_MAJOR_EN to stream column-major instead of row-major.
module mat_result_drain #(
  parameter int W_OUT = 32,
  parameter int N     = 2,
  parameter int W_CNT = 8,
  localparam int RC_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    valid_in,
  input  logic                    last_in,
  input  logic [N*N*W_OUT-1:0]    result_in,
  output logic                    cap_ready,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [W_OUT-1:0] m_data,
  output logic [RC_W-1:0]         m_row,
  output logic [RC_W-1:0]         m_col,
  output logic                    m_last,
  input  logic                    clr_err,
  output logic                    overflow,
  output logic [W_CNT-1:0]        drop_cnt
);

  localparam int NE    = N * N;
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [NE-1:0][W_OUT-1:0]    mat_q;

  logic                        at_last;
  logic                        beat_done;
  logic                        cap_evt;
  logic                        drop_evt;
  logic [RC_W-1:0]             row;
  logic [RC_W-1:0]             col;
  logic [IDX_W-1:0]            phys;

  assign at_last   = (idx == IDX_LAST);
  assign beat_done = m_valid & m_ready;

  // The final handshake frees the buffer in the same cycle, so a new tile
  // can be taken without a bubble between matrices.
  assign cap_ready = (state == IDLE) | (beat_done & at_last);
  assign cap_evt   = valid_in & last_in & cap_ready;
  assign drop_evt  = valid_in & last_in & ~cap_ready;

  // Stream index -> (row, col) -> storage slot. Storage is always [row][col].
  always_comb begin
`ifdef MAT_DRAIN_COL_MAJOR_EN
    row = RC_W'(int'(idx) % N);
    col = RC_W'(int'(idx) / N);
`else
    row = RC_W'(int'(idx) / N);
    col = RC_W'(int'(idx) % N);
`endif
    phys = IDX_W'(int'(row) * N + int'(col));
  end

  assign m_row  = row;
  assign m_col  = col;
  assign m_data = $signed(mat_q[phys]);
  assign m_last = at_last & m_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      m_valid <= 1'b0;
      idx     <= '0;
      mat_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cap_evt) begin
            mat_q   <= result_in;
            idx     <= '0;
            state   <= STREAM;
            m_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (beat_done) begin
            if (!at_last) begin
              idx <= idx + 1'b1;
            end else if (cap_evt) begin
              // Back-to-back tile: reload and restart without leaving STREAM.
              mat_q <= result_in;
              idx   <= '0;
            end else begin
              idx     <= '0;
              state   <= IDLE;
              m_valid <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          idx     <= '0;
        end
      endcase
    end
  end

  // Drop bookkeeping; a clear in the same cycle as a drop discards that drop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_err) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop_evt) begin
      overflow <= 1'b1;
      if (drop_cnt != {W_CNT{1'b1}}) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mat_result_drain.sv
// Purpose : directed self-checking bench for mat_result_drain (N=2, W_OUT=32, W_CNT=8).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpr. : exercises both free-running and stalled m_ready patterns.
module tb_mat_result_drain;

  localparam int W_OUT = 32;
  localparam int N     = 2;
  localparam int W_CNT = 8;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b0;
  logic                    valid_in = 1'b0;
  logic                    last_in = 1'b0;
  logic [N*N*W_OUT-1:0]    result_in = '0;
  logic                    cap_ready;
  logic                    m_valid;
  logic                    m_ready = 1'b0;
  logic signed [W_OUT-1:0] m_data;
  logic [0:0]              m_row;
  logic [0:0]              m_col;
  logic                    m_last;
  logic                    clr_err = 1'b0;
  logic                    overflow;
  logic [W_CNT-1:0]        drop_cnt;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_m [4];   // expected matrix, slot = row*2 + col
  int          beat;

  always #5 clk = ~clk;

  mat_result_drain #(.W_OUT(W_OUT), .N(N), .W_CNT(W_CNT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .result_in (result_in),
    .cap_ready (cap_ready),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_row     (m_row),
    .m_col     (m_col),
    .m_last    (m_last),
    .clr_err   (clr_err),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat number -> matrix slot (row*2+col) in the selected streaming order.
  function automatic int slot_of(input int b);
`ifdef MAT_DRAIN_COL_MAJOR_EN
    return (b % 2) * 2 + b / 2;
`else
    return b;
`endif
  endfunction

  // Present a tile for one edge (called while cap_ready=1), elements given row-major.
  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    result_in = {d, c, b, a};
    exp_m[0] = a; exp_m[1] = b; exp_m[2] = c; exp_m[3] = d;
    beat = 0;
    valid_in = 1'b1;
    last_in  = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  // Consume beats until 'upto' handshakes; mode 0: ready always, mode 1: ready 1,0,0 repeating.
  task automatic drain(input string tag, input int mode, input int upto);
    int cyc = 0;
    while (beat < upto && cyc < 60) begin
      m_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      @(negedge clk);
      check({tag, ".vld"}, m_valid, 1);
      check({tag, ".dat"}, {32'b0, m_data}, {32'b0, exp_m[slot_of(beat)]});
      check({tag, ".row"}, m_row, slot_of(beat) / 2);
      check({tag, ".col"}, m_col, slot_of(beat) % 2);
      check({tag, ".last"}, m_last, beat == 3);
      if (m_ready) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".beats"}, beat, upto);
    m_ready = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    check({tag, ".idle_vld"}, m_valid, 0);
    check({tag, ".idle_rdy"}, cap_ready, 1);
    check({tag, ".idle_last"}, m_last, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    check("rst.vld", m_valid, 0);
    check("rst.last", m_last, 0);
    check("rst.dat", {32'b0, m_data}, 0);
    check("rst.row", m_row, 0);
    check("rst.col", m_col, 0);
    check("rst.ovf", overflow, 0);
    check("rst.drop", drop_cnt, 0);
    resetn = 1'b1;
    #1;
    check("rst.caprdy", cap_ready, 1);
    @(posedge clk); #1;

    // Basic stream of [[1,2],[3,4]]
    load(1, 2, 3, 4);
    drain("t1", 0, 4);
    idle_chk("t1");

    // Partial accumulation ignored, then a signed tile
    result_in = {32'd9, 32'd9, 32'd9, 32'd9};
    valid_in = 1'b1;
    last_in  = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    check("t2.nocap_vld", m_valid, 0);
    @(posedge clk); #1;
    load(-5, 7, 0, -1);
    drain("t2", 0, 4);
    idle_chk("t2");

    // Backpressure 1,0,0 pattern
    load(21, 22, 23, 24);
    drain("t3", 1, 4);
    idle_chk("t3");

    // Back-to-back capture on the final handshake
    load(1, 2, 3, 4);
    drain("t4a", 0, 3);
    m_ready   = 1'b1;
    result_in = {32'd40, 32'd30, 32'd20, 32'd10};
    valid_in  = 1'b1;
    last_in   = 1'b1;
    @(negedge clk);
    check("t4.caprdy", cap_ready, 1);
    check("t4.last", m_last, 1);
    check("t4.dat", {32'b0, m_data}, 4);
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    exp_m[0] = 10; exp_m[1] = 20; exp_m[2] = 30; exp_m[3] = 40;
    beat = 0;
    drain("t4b", 0, 4);
    check("t4.ovf", overflow, 0);
    idle_chk("t4");

    // Drop during beat 2
    load(1, 2, 3, 4);
    drain("t5a", 0, 1);
    m_ready   = 1'b0;
    result_in = {32'd9, 32'd9, 32'd9, 32'd9};
    valid_in  = 1'b1;
    last_in   = 1'b1;
    @(negedge clk);
    check("t5.caprdy", cap_ready, 0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    @(negedge clk);
    check("t5.ovf", overflow, 1);
    check("t5.drop", drop_cnt, 1);
    check("t5.hold", {32'b0, m_data}, {32'b0, exp_m[slot_of(1)]});
    @(posedge clk); #1;
    drain("t5b", 0, 4);
    idle_chk("t5");

    // Saturation, then clear (clear beats a simultaneous drop)
    load(5, 6, 7, 8);
    m_ready  = 1'b0;
    valid_in = 1'b1;
    last_in  = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    @(negedge clk);
    check("sat.drop", drop_cnt, 255);
    check("sat.ovf", overflow, 1);
    check("sat.vld", m_valid, 1);
    check("sat.dat", {32'b0, m_data}, 5);
    @(posedge clk); #1;
    clr_err  = 1'b1;
    valid_in = 1'b1;
    last_in  = 1'b1;
    @(posedge clk); #1;
    clr_err  = 1'b0;
    valid_in = 1'b0;
    last_in  = 1'b0;
    @(negedge clk);
    check("clr.ovf", overflow, 0);
    check("clr.drop", drop_cnt, 0);
    @(posedge clk); #1;
    valid_in = 1'b1;
    last_in  = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    @(negedge clk);
    check("redrop.drop", drop_cnt, 1);
    check("redrop.ovf", overflow, 1);
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    drain("sat", 0, 4);
    idle_chk("sat");

    // Reset mid-stream
    load(5, 6, 7, 8);
    drain("t6a", 0, 2);
    resetn = 1'b0;
    #2;
    check("t6.rst_vld", m_valid, 0);
    check("t6.rst_last", m_last, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("t6.caprdy", cap_ready, 1);
    check("t6.vld", m_valid, 0);
    check("t6.dat", {32'b0, m_data}, 0);
    @(posedge clk); #1;
    load(11, 12, 13, 14);
    drain("t6b", 0, 4);
    idle_chk("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
